// File: rtl/div_acc.sv
// Divide accelerator: restoring divider that replaces the software divide loop by injecting pre-load pairs.
// Build option: define DIV_ACC_RADIX4_EN to retire two quotient bits per DIVIDE cycle (8 cycles instead of 16).
module div_acc #(
  parameter int W      = 16,
  parameter int Q_ADDR = 1,
  parameter int R_ADDR = 2
) (
  input  logic         Clk,
  input  logic         Reset_N,
  input  logic         StartDiv102,
  input  logic [W-1:0] Divident,
  input  logic [W-1:0] Divisor,
  input  logic         AccGrant,
  output logic         SelAccInst101,
  output logic [W-1:0] Inst0FromAcc101,
  output logic [W-1:0] Inst1FromAcc101,
  output logic         AccBusy,
  output logic         AccBypass
);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, INJECT} state_t;

  typedef struct packed {
    logic [W-1:0] rem;
    logic [W-1:0] quo;
  } div_t;

  localparam logic [W-1:0] C_DEQA = W'(16'hEC10);
  localparam logic [W-1:0] C_MEQD = W'(16'hE308);

`ifdef DIV_ACC_RADIX4_EN
  localparam logic [3:0] LAST_STEP = 4'd7;
`else
  localparam logic [3:0] LAST_STEP = 4'd15;
`endif

  state_t       state_q;
  logic [W-1:0] dvd_q, dvs_q;
  div_t         div_q, div_d;
  logic         small_q;
  logic [3:0]   cnt_q;
  logic [1:0]   pair_q;
  logic         busy_q, bypass_q;
  logic [W-1:0] inst0_q, inst1_q;
  logic [W-1:0] x_w;

  // One restoring step: shift in the next dividend bit, keep the trial difference if it did not borrow.
  function automatic div_t div_step(input div_t cur, input logic [W-1:0] dvs);
    logic [W:0] trial;
    div_t       nxt;
    trial = {cur.rem, cur.quo[W-1]} - {1'b0, dvs};
    if (!trial[W]) begin
      nxt.rem = trial[W-1:0];
      nxt.quo = {cur.quo[W-2:0], 1'b1};
    end else begin
      nxt.rem = {cur.rem[W-2:0], cur.quo[W-1]};
      nxt.quo = {cur.quo[W-2:0], 1'b0};
    end
    return nxt;
  endfunction

  function automatic logic [2*W-1:0] pair_word(input logic [1:0] idx,
                                               input logic [W-1:0] qm1,
                                               input logic [W-1:0] rp1);
    logic [2*W-1:0] w;
    case (idx)
      2'd0:    w = {qm1, C_DEQA};
      2'd1:    w = {W'(Q_ADDR), C_MEQD};
      2'd2:    w = {rp1, C_DEQA};
      default: w = {W'(R_ADDR), C_MEQD};
    endcase
    return w;
  endfunction

  assign x_w = dvd_q - W'(1);

  always_comb begin
`ifdef DIV_ACC_RADIX4_EN
    div_d = div_step(div_step(div_q, dvs_q), dvs_q);
`else
    div_d = div_step(div_q, dvs_q);
`endif
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      div_q    <= '0;
      small_q  <= 1'b0;
      cnt_q    <= '0;
      pair_q   <= '0;
      busy_q   <= 1'b0;
      bypass_q <= 1'b0;
      inst0_q  <= '0;
      inst1_q  <= '0;
    end else begin
      bypass_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (StartDiv102) begin
            dvd_q    <= Divident;
            dvs_q    <= Divisor;
            busy_q   <= 1'b1;
            state_q  <= CHECK;
            // Non-positive operands are flagged now so the bypass pulse lands in the CHECK cycle.
            bypass_q <= Divident[W-1] | ~|Divident | Divisor[W-1] | ~|Divisor;
          end
        end
        CHECK: begin
          if (bypass_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q.rem <= '0;
            div_q.quo <= x_w;
            small_q   <= (x_w < dvs_q);
            cnt_q     <= '0;
            state_q   <= DIVIDE;
          end
        end
        DIVIDE: begin
          div_q <= div_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_STEP - 4'd1 && small_q)
            bypass_q <= 1'b1;
          if (cnt_q == LAST_STEP) begin
            if (small_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              pair_q             <= 2'd0;
              {inst0_q, inst1_q} <= pair_word(2'd0, div_d.quo, div_d.rem + W'(1));
              state_q            <= INJECT;
            end
          end
        end
        INJECT: begin
          if (AccGrant) begin
            if (pair_q == 2'd3) begin
              pair_q  <= 2'd0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              pair_q             <= pair_q + 2'd1;
              {inst0_q, inst1_q} <= pair_word(pair_q + 2'd1, div_q.quo, div_q.rem + W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SelAccInst101   = (state_q == INJECT) & AccGrant;
  assign Inst0FromAcc101 = inst0_q;
  assign Inst1FromAcc101 = inst1_q;
  assign AccBusy         = busy_q;
  assign AccBypass       = bypass_q;

endmodule

// File: tb/tb_div_acc.sv
// Bench for div_acc: directed steps with a queue of expected injected pairs.
module tb_div_acc;

`ifdef DIV_ACC_RADIX4_EN
  localparam int DIVC = 8;
`else
  localparam int DIVC = 16;
`endif

  logic        Clk;
  logic        Reset_N;
  logic        StartDiv102;
  logic [15:0] Divident;
  logic [15:0] Divisor;
  logic        AccGrant;
  logic        SelAccInst101;
  logic [15:0] Inst0FromAcc101;
  logic [15:0] Inst1FromAcc101;
  logic        AccBusy;
  logic        AccBypass;

  div_acc dut (
    .Clk             (Clk),
    .Reset_N         (Reset_N),
    .StartDiv102     (StartDiv102),
    .Divident        (Divident),
    .Divisor         (Divisor),
    .AccGrant        (AccGrant),
    .SelAccInst101   (SelAccInst101),
    .Inst0FromAcc101 (Inst0FromAcc101),
    .Inst1FromAcc101 (Inst1FromAcc101),
    .AccBusy         (AccBusy),
    .AccBypass       (AccBypass)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          cyc_idx, busy_cnt, byp_cnt, byp_cyc, sel_cnt, first_sel;
  logic [15:0] obs_a[8];
  logic [15:0] m1, m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic of the replaced loop: pre-load M1 = Q-1, M2 = R'+1.
  task automatic expect_div(input int dvd, input int dvs);
    int x, q, r;
    x = dvd - 1;
    q = x / dvs;
    r = x % dvs;
    exp_q.push_back({q[15:0], 16'hEC10});
    exp_q.push_back({16'd1, 16'hE308});
    exp_q.push_back({16'(r + 1), 16'hEC10});
    exp_q.push_back({16'd2, 16'hE308});
  endtask

  task automatic clr();
    cyc_idx = 0; busy_cnt = 0; byp_cnt = 0; byp_cyc = -1; sel_cnt = 0; first_sel = -1;
  endtask

  task automatic sample();
    logic [31:0] e;
    if (AccBusy) busy_cnt++;
    if (AccBypass) begin
      byp_cnt++;
      byp_cyc = cyc_idx;
    end
    if (SelAccInst101) begin
      if (first_sel < 0) first_sel = cyc_idx;
      if (sel_cnt < 8) obs_a[sel_cnt] = Inst0FromAcc101;
      sel_cnt++;
      chk("pair_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pair_value", {Inst0FromAcc101, Inst1FromAcc101}, e);
      end
    end
  endtask

  // Drive one cycle's inputs just after the edge, sample outputs, advance to the next cycle.
  task automatic cyc(input logic g, input logic s, input logic [15:0] a, input logic [15:0] b);
    AccGrant = g; StartDiv102 = s; Divident = a; Divisor = b;
    #2;
    sample();
    cyc_idx++;
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n, input logic g);
    for (int i = 0; i < n; i++) cyc(g, 1'b0, 16'd0, 16'd0);
  endtask

  initial begin
    Reset_N = 1'b0; StartDiv102 = 1'b0; Divident = '0; Divisor = '0; AccGrant = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_sel", 32'(SelAccInst101), 32'd0);
    chk("rst_inst", {Inst0FromAcc101, Inst1FromAcc101}, 32'd0);
    chk("rst_busy", 32'(AccBusy), 32'd0);
    chk("rst_bypass", 32'(AccBypass), 32'd0);
    @(posedge Clk);
    #1;
    Reset_N = 1'b1;
    @(posedge Clk);
    #1;

    // 20000 / 10 with continuous grant
    clr(); expect_div(20000, 10);
    cyc(1'b1, 1'b1, 16'd20000, 16'd10);
    run(30, 1'b1);
    chk("t1_busy_cycles", busy_cnt, 1 + DIVC + 4);
    chk("t1_first_pair", first_sel, DIVC + 2);
    chk("t1_pairs", sel_cnt, 4);
    chk("t1_bypass", byp_cnt, 0);
    chk("t1_drained", exp_q.size(), 0);

    // 25 / 10, then one software pass on the pre-loaded values
    clr(); expect_div(25, 10);
    cyc(1'b1, 1'b1, 16'd25, 16'd10);
    run(25, 1'b1);
    chk("t2_pairs", sel_cnt, 4);
    m1 = obs_a[0] + 16'd1;
    m2 = obs_a[2] - 16'd10;
    chk("t2_m1_final", 32'(m1), 32'd3);
    chk("t2_m2_final", 32'(m2), 32'h0000FFFB);
    chk("t2_drained", exp_q.size(), 0);

    // Q == 1: bypass at the end of DIVIDE
    clr();
    cyc(1'b1, 1'b1, 16'd10, 16'd10);
    run(25, 1'b1);
    chk("t3_bypass_cnt", byp_cnt, 1);
    chk("t3_bypass_cycle", byp_cyc, DIVC + 1);
    chk("t3_no_sel", sel_cnt, 0);
    chk("t3_busy_cycles", busy_cnt, DIVC + 1);

    // Zero divisor: bypass in CHECK
    clr();
    cyc(1'b1, 1'b1, 16'd50, 16'd0);
    run(4, 1'b1);
    chk("t4a_bypass_cnt", byp_cnt, 1);
    chk("t4a_bypass_cycle", byp_cyc, 1);
    chk("t4a_busy_cycles", busy_cnt, 1);
    chk("t4a_no_sel", sel_cnt, 0);

    // Negative dividend: bypass in CHECK
    clr();
    cyc(1'b1, 1'b1, 16'h8005, 16'd3);
    run(4, 1'b1);
    chk("t4b_bypass_cnt", byp_cnt, 1);
    chk("t4b_bypass_cycle", byp_cyc, 1);
    chk("t4b_busy_cycles", busy_cnt, 1);
    chk("t4b_no_sel", sel_cnt, 0);

    // 32767 / 1 with grant 1,0,0,1,1,1 and a Start during INJECT
    clr(); expect_div(32767, 1);
    cyc(1'b0, 1'b1, 16'd32767, 16'd1);
    run(DIVC + 1, 1'b0);
    cyc(1'b1, 1'b0, 16'd0, 16'd0);
    cyc(1'b0, 1'b1, 16'd500, 16'd3);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0, 16'd0);
    run(25, 1'b0);
    chk("t5_pairs", sel_cnt, 4);
    chk("t5_first_pair", first_sel, DIVC + 2);
    chk("t5_busy_cycles", busy_cnt, DIVC + 7);
    chk("t5_bypass", byp_cnt, 0);
    chk("t5_drained", exp_q.size(), 0);

    // Reset during DIVIDE, then a clean restart with 100 / 7
    clr();
    cyc(1'b1, 1'b1, 16'd100, 16'd7);
    run(6, 1'b1);
    Reset_N = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(AccBusy), 32'd0);
    chk("t6_rst_sel", 32'(SelAccInst101), 32'd0);
    @(posedge Clk);
    #1;
    Reset_N = 1'b1;
    run(DIVC + 8, 1'b1);
    chk("t6_abandoned", sel_cnt, 0);
    clr(); expect_div(100, 7);
    cyc(1'b1, 1'b1, 16'd100, 16'd7);
    run(30, 1'b1);
    chk("t6_first_pair", first_sel, DIVC + 2);
    chk("t6_pairs", sel_cnt, 4);
    chk("t6_bypass", byp_cnt, 0);
    chk("t6_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
